// File: rtl/instr_fetch_buffer.sv
// Instruction store plus sequencer that issues one word per accepted cycle to PSIMD decode.
// Define IFB_PERF_EN to add the saturating perf_issued / perf_stall counters.
module instr_fetch_buffer #(
  parameter int ILEN  = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [ILEN-1:0] load_data,
  input  logic            start,
  input  logic [AW:0]     prog_len,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_addr,
  input  logic            instr_ready,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [AW-1:0]   instr_pc,
  output logic            done
`ifdef IFB_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t          state, state_n;
  logic [AW:0]     pc, len;
  logic [ILEN-1:0] mem [DEPTH];
  logic            free, fire, stall;
  logic            do_start, do_redir, do_issue, do_fin;

  assign free  = ~instr_valid | instr_ready;
  assign fire  = instr_valid & instr_ready;
  assign stall = instr_valid & ~instr_ready;

  // Program store has no reset so a loaded program survives rst.
  always_ff @(posedge clk)
    if (load_en && state != FETCH) mem[load_addr] <= load_data;

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_redir = 1'b0;
    do_issue = 1'b0;
    do_fin   = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        do_start = 1'b1;
        state_n  = FETCH;
      end
      FETCH: begin
        // Redirect wins over both issue and exhaustion.
        if (redirect_valid) do_redir = 1'b1;
        else if (free) begin
          if (pc < len) do_issue = 1'b1;
          else begin
            do_fin  = 1'b1;
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      len         <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      done        <= 1'b0;
    end else begin
      if (do_start) begin
        len  <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
        pc   <= '0;
        done <= 1'b0;
      end
      if (do_redir) begin
        instr_valid <= 1'b0;
        pc          <= {1'b0, redirect_addr};
      end
      if (do_issue) begin
        instr       <= mem[pc[AW-1:0]];
        instr_pc    <= pc[AW-1:0];
        instr_valid <= 1'b1;
        pc          <= pc + (AW+1)'(1);
      end
      if (do_fin) begin
        instr_valid <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

`ifdef IFB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (do_start) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (stall && perf_stall != '1) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: cycle table plus scoreboard of issued words.
module tb_instr_fetch_buffer;
  localparam int ILEN = 32, DEPTH = 64, AW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_en = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [ILEN-1:0] load_data = '0;
  logic            start = 1'b0;
  logic [AW:0]     prog_len = '0;
  logic            redirect_valid = 1'b0;
  logic [AW-1:0]   redirect_addr = '0;
  logic            instr_ready = 1'b1;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [AW-1:0]   instr_pc;
  logic            done;
`ifdef IFB_PERF_EN
  logic [31:0]     perf_issued, perf_stall;
`endif

  instr_fetch_buffer #(.ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .prog_len(prog_len), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .done(done)
`ifdef IFB_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   pc;
    logic [ILEN-1:0] w;
  } exp_t;

  typedef struct {
    logic        start;
    logic [AW:0] plen;
    logic        ready;
    logic        v;
    logic [AW-1:0] pc;
    logic        dn;
  } vec_t;

  exp_t            sb[$];
  logic [ILEN-1:0] model [DEPTH];
  int              ncmp = 0, nfail = 0, nfire = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_prog(input int plen);
    int n;
    n = (plen > DEPTH) ? DEPTH : plen;
    for (int i = 0; i < n; i++) sb.push_back('{pc: AW'(i), w: model[i]});
  endtask

  task automatic kick(input int plen);
    prog_len = (AW+1)'(plen);
    start    = 1'b1;
    push_prog(plen);
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 300) begin
      step();
      k++;
    end
    chk(nm, done, 1);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  // Scoreboard consumer: each accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_done_excl", instr_valid & done, 0);
      if (instr_valid && instr_ready) begin
        nfire++;
        if (sb.size() == 0) chk("sb_unexpected_issue", {58'd0, instr_pc}, 64'hFFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_instr", instr, e.w);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[17];
    logic [ILEN-1:0] prog [4];
    int f0, k;
    prog = '{32'h0000105B, 32'h0000115B, 32'h0800105B, 32'h0810A75B};
    for (int i = 0; i < DEPTH; i++)
      model[i] = (i < 4) ? prog[i] : (32'hA500_0000 ^ (32'(i) * 32'h0101_0101));

    // Test 1 (full rate) followed by test 2 (three stall cycles at pc 1).
    tv[0]  = '{1, 4, 1, 0, 0, 0};
    tv[1]  = '{0, 4, 1, 0, 0, 0};
    tv[2]  = '{0, 4, 1, 1, 0, 0};
    tv[3]  = '{0, 4, 1, 1, 1, 0};
    tv[4]  = '{0, 4, 1, 1, 2, 0};
    tv[5]  = '{0, 4, 1, 1, 3, 0};
    tv[6]  = '{0, 4, 1, 0, 0, 1};
    tv[7]  = '{1, 4, 1, 0, 0, 1};
    tv[8]  = '{0, 4, 1, 0, 0, 0};
    tv[9]  = '{0, 4, 1, 1, 0, 0};
    tv[10] = '{0, 4, 0, 1, 1, 0};
    tv[11] = '{0, 4, 0, 1, 1, 0};
    tv[12] = '{0, 4, 0, 1, 1, 0};
    tv[13] = '{0, 4, 1, 1, 1, 0};
    tv[14] = '{0, 4, 1, 1, 2, 0};
    tv[15] = '{0, 4, 1, 1, 3, 0};
    tv[16] = '{0, 4, 1, 0, 0, 1};

    step(); step();
    rst = 1'b0;
    chk("rst_valid", instr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);

    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_addr = AW'(i); load_data = model[i];
      step();
    end
    load_en = 1'b0;

    for (int i = 0; i < 17; i++) begin
      start = tv[i].start; prog_len = tv[i].plen; instr_ready = tv[i].ready;
      if (tv[i].start) push_prog(int'(tv[i].plen));
      chk($sformatf("vec%0d_valid", i), instr_valid, tv[i].v);
      chk($sformatf("vec%0d_done", i), done, tv[i].dn);
      if (tv[i].v) chk($sformatf("vec%0d_pc", i), instr_pc, tv[i].pc);
      step();
    end
    start = 1'b0; instr_ready = 1'b1;
    chk("t2_sb_empty", sb.size(), 0);
`ifdef IFB_PERF_EN
    chk("t2_perf_stall", perf_stall, 3);
    chk("t2_perf_issued", perf_issued, 4);
`endif

    // Test 3: redirect to 0 while pc 2 is being accepted.
    f0 = nfire;
    kick(4);
    k = 0;
    while (!(instr_valid && instr_pc == 2) && k < 20) begin step(); k++; end
    chk("t3_reach_pc2", instr_pc, 2);
    redirect_valid = 1'b1; redirect_addr = '0;
    step();
    redirect_valid = 1'b0;
    sb.delete();
    push_prog(4);
    chk("t3_bubble", instr_valid, 0);
    step();
    chk("t3_after_bubble_valid", instr_valid, 1);
    chk("t3_after_bubble_pc", instr_pc, 0);
    run_to_done("t3_done");
    chk("t3_total_issued", nfire - f0, 7);
`ifdef IFB_PERF_EN
    chk("t3_perf_issued", perf_issued, 7);
`endif

    // Test 4: empty program, then an oversize one that clamps to DEPTH.
    kick(0);
    chk("t4_len0_done_n1", done, 0);
    chk("t4_len0_valid_n1", instr_valid, 0);
    step();
    chk("t4_len0_done_n2", done, 1);
    chk("t4_len0_valid_n2", instr_valid, 0);
    f0 = nfire;
    kick(100);
    run_to_done("t4_len100_done");
    chk("t4_len100_issued", nfire - f0, 64);

    // Test 5: reset mid-fetch, then rerun from retained memory.
    kick(4);
    k = 0;
    while (!(instr_valid && instr_pc == 2) && k < 20) begin step(); k++; end
    chk("t5_reach_pc2", instr_pc, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("t5_rst_valid", instr_valid, 0);
    chk("t5_rst_instr", instr, 0);
    chk("t5_rst_pc", instr_pc, 0);
    chk("t5_rst_done", done, 0);
    step(); step();
    chk("t5_idle_valid", instr_valid, 0);
    chk("t5_idle_done", done, 0);
    kick(4);
    run_to_done("t5_rerun_done");

    // Test 6: writes during FETCH are dropped; writes in DONE land.
    kick(4);
    load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    run_to_done("t6_fetch_write_done");
    kick(4);
    run_to_done("t6_unchanged_done");
    load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEADBEEF;
    model[1] = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    kick(4);
    run_to_done("t6_done_write_done");
    // Write coinciding with start must be visible to the very first fetch.
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'h0BAD_F00D;
    model[0] = 32'h0BAD_F00D;
    kick(4);
    load_en = 1'b0;
    run_to_done("t6_start_write_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
